// File: rtl/imm_encoder.sv
// imm_encoder: packs an immediate plus register/funct/opcode fields into an
// RV32I instruction word, flagging immediates that the selected format cannot
// represent. Two-stage valid/ready pipeline with sticky error bookkeeping.
module imm_encoder #(
  parameter int CNT_W        = 16,
  parameter bit ERR_ZERO_IMM = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       ext_ctrl,
  input  logic [31:0]      imm,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_word,
  output logic             out_err,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             clr_err
);

  // Format selects, one-hot, matching the immediate extender's encoding.
  localparam logic [6:0] EXT_CTRL_SHAMT = 7'b100_0000;
  localparam logic [6:0] EXT_CTRL_ITYPE = 7'b010_0000;
  localparam logic [6:0] EXT_CTRL_STYPE = 7'b001_0000;
  localparam logic [6:0] EXT_CTRL_BTYPE = 7'b000_1000;
  localparam logic [6:0] EXT_CTRL_UTYPE = 7'b000_0100;
  localparam logic [6:0] EXT_CTRL_JAL   = 7'b000_0010;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Stage 1 registers
  logic        s1_v_r;
  logic [6:0]  s1_ext_r;
  logic [31:0] s1_imm_r;
  logic [6:0]  s1_opcode_r;
  logic [4:0]  s1_rd_r;
  logic [4:0]  s1_rs1_r;
  logic [4:0]  s1_rs2_r;
  logic [2:0]  s1_funct3_r;
  logic [6:0]  s1_funct7_r;
  logic        s1_range_err_r;

  // Stage 2 registers
  logic        s2_v_r;
  logic [31:0] s2_word_r;
  logic        s2_err_r;

  logic        err_flag_r;
  logic [CNT_W-1:0] err_cnt_r;

  logic        s1_adv_s;
  logic        s2_adv_s;
  logic        range_err_s;
  logic [31:0] pack_imm_s;
  logic [31:0] pack_word_s;
  logic        consume_err_s;

  assign s2_adv_s = !s2_v_r || out_ready;
  assign s1_adv_s = !s1_v_r || s2_adv_s;
  assign in_ready = s1_adv_s;

  assign out_valid = s2_v_r;
  assign out_word  = s2_word_r;
  assign out_err   = s2_err_r;
  assign err_flag  = err_flag_r;
  assign err_cnt   = err_cnt_r;

  assign consume_err_s = s2_v_r && out_ready && s2_err_r;

  // Representability check on the incoming immediate for the selected format.
  always_comb begin
    range_err_s = 1'b1;
    case (ext_ctrl)
      EXT_CTRL_SHAMT: range_err_s = (imm[31:5] != 27'd0);
      EXT_CTRL_ITYPE,
      EXT_CTRL_STYPE: range_err_s = !((imm[31:11] == 21'd0) || (imm[31:11] == {21{1'b1}}));
      EXT_CTRL_BTYPE: range_err_s = imm[0] || !((imm[31:12] == 20'd0) || (imm[31:12] == {20{1'b1}}));
      EXT_CTRL_JAL:   range_err_s = imm[0] || !((imm[31:20] == 12'd0) || (imm[31:20] == {12{1'b1}}));
      EXT_CTRL_UTYPE: range_err_s = (imm[11:0] != 12'd0);
      default:        range_err_s = 1'b1;
    endcase
  end

  // Field packing from stage 1; a bad immediate is zeroed before packing so
  // every immediate bit position in the word reads 0.
  always_comb begin
    if (ERR_ZERO_IMM && s1_range_err_r) begin
      pack_imm_s = 32'd0;
    end else begin
      pack_imm_s = s1_imm_r;
    end
    pack_word_s = 32'd0;
    case (s1_ext_r)
      EXT_CTRL_ITYPE: pack_word_s = {pack_imm_s[11:0], s1_rs1_r, s1_funct3_r, s1_rd_r, s1_opcode_r};
      EXT_CTRL_SHAMT: pack_word_s = {s1_funct7_r, pack_imm_s[4:0], s1_rs1_r, s1_funct3_r, s1_rd_r, s1_opcode_r};
      EXT_CTRL_STYPE: pack_word_s = {pack_imm_s[11:5], s1_rs2_r, s1_rs1_r, s1_funct3_r,
                                     pack_imm_s[4:0], s1_opcode_r};
      EXT_CTRL_BTYPE: pack_word_s = {pack_imm_s[12], pack_imm_s[10:5], s1_rs2_r, s1_rs1_r, s1_funct3_r,
                                     pack_imm_s[4:1], pack_imm_s[11], s1_opcode_r};
      EXT_CTRL_UTYPE: pack_word_s = {pack_imm_s[31:12], s1_rd_r, s1_opcode_r};
      EXT_CTRL_JAL:   pack_word_s = {pack_imm_s[20], pack_imm_s[10:1], pack_imm_s[11], pack_imm_s[19:12],
                                     s1_rd_r, s1_opcode_r};
      default:        pack_word_s = 32'd0;
    endcase
  end

  // Stage 1: capture request fields and the range verdict on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_r <= 1'b0;
    end else if (s1_adv_s) begin
      s1_v_r <= in_valid;
      if (in_valid) begin
        s1_ext_r       <= ext_ctrl;
        s1_imm_r       <= imm;
        s1_opcode_r    <= opcode;
        s1_rd_r        <= rd;
        s1_rs1_r       <= rs1;
        s1_rs2_r       <= rs2;
        s1_funct3_r    <= funct3;
        s1_funct7_r    <= funct7;
        s1_range_err_r <= range_err_s;
      end
    end
  end

  // Stage 2: register the packed word; holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v_r    <= 1'b0;
      s2_word_r <= 32'd0;
      s2_err_r  <= 1'b0;
    end else if (s2_adv_s) begin
      s2_v_r <= s1_v_r;
      if (s1_v_r) begin
        s2_word_r <= pack_word_s;
        s2_err_r  <= s1_range_err_r;
      end
    end
  end

  // Sticky error flag and saturating error counter; clear has priority.
  always_ff @(posedge clk) begin
    if (rst || clr_err) begin
      err_flag_r <= 1'b0;
      err_cnt_r  <= {CNT_W{1'b0}};
    end else if (consume_err_s) begin
      err_flag_r <= 1'b1;
      if (err_cnt_r != CNT_MAX) begin
        err_cnt_r <= err_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder with an expected-result scoreboard.
module tb_imm_encoder;

  localparam logic [6:0] C_SHAMT = 7'b100_0000;
  localparam logic [6:0] C_ITYPE = 7'b010_0000;
  localparam logic [6:0] C_STYPE = 7'b001_0000;
  localparam logic [6:0] C_BTYPE = 7'b000_1000;
  localparam logic [6:0] C_UTYPE = 7'b000_0100;
  localparam logic [6:0] C_JAL   = 7'b000_0010;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  ext_ctrl;
  logic [31:0] imm;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        out_err;
  logic        err_flag;
  logic [15:0] err_cnt;
  logic        clr_err;

  typedef struct {
    logic [31:0] word;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int pass_cnt = 0;
  int total_cnt = 0;
  int hs_cnt = 0;

  imm_encoder #(.CNT_W(16), .ERR_ZERO_IMM(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ext_ctrl(ext_ctrl), .imm(imm), .opcode(opcode), .rd(rd), .rs1(rs1),
    .rs2(rs2), .funct3(funct3), .funct7(funct7), .out_valid(out_valid),
    .out_ready(out_ready), .out_word(out_word), .out_err(out_err),
    .err_flag(err_flag), .err_cnt(err_cnt), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Scoreboard monitor: every output handshake pops and compares one entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      hs_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_output", out_word, 32'hxxxx_xxxx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("word", out_word, e.word);
        chk("err", {31'd0, out_err}, {31'd0, e.err});
      end
    end
  end

  // Drive one request; called at posedge+1, returns at posedge+1 after acceptance.
  task automatic send(input logic [6:0] c, input logic [31:0] i, input logic [6:0] op,
                      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] ew, input logic ee);
    bit done;
    exp_t e;
    done = 1'b0;
    in_valid = 1'b1; ext_ctrl = c; imm = i; opcode = op; rd = d;
    rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        e.word = ew; e.err = ee;
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 50 && sb.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    chk("drain", sb.size(), 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    int hs0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_err = 1'b0;
    ext_ctrl = 7'd0; imm = 32'd0; opcode = 7'd0; rd = 5'd0; rs1 = 5'd0;
    rs2 = 5'd0; funct3 = 3'd0; funct7 = 7'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_word", out_word, 32'd0);
    chk("rst_out_err", {31'd0, out_err}, 32'd0);
    chk("rst_err_flag", {31'd0, err_flag}, 32'd0);
    chk("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // ITYPE with latency check
    send(C_ITYPE, 32'hFFFF_FFFF, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF0_0093, 1'b0);
    chk("lat_n1", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("lat_n2", {31'd0, out_valid}, 32'd1);
    drain();

    send(C_BTYPE, 32'hFFFF_FFFC, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFE20_8EE3, 1'b0);
    send(C_JAL,   32'h0000_0800, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_00EF, 1'b0);
    send(C_UTYPE, 32'h1234_5000, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_52B7, 1'b0);
    send(C_SHAMT, 32'd5, 7'h13, 5'd1, 5'd1, 5'd0, 3'd5, 7'h20, 32'h4050_D093, 1'b0);
    send(C_STYPE, 32'hFFFF_FFF8, 7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'hFE51_2C23, 1'b0);
    send(C_JAL,   32'hFFFF_FFFE, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F0EF, 1'b0);
    drain();
    chk("no_err_cnt", {16'd0, err_cnt}, 32'd0);

    // Range error, bookkeeping, and clear
    send(C_ITYPE, 32'd2048, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0093, 1'b1);
    drain();
    chk("err_cnt_1", {16'd0, err_cnt}, 32'd1);
    chk("err_flag_1", {31'd0, err_flag}, 32'd1);
    clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
    chk("clr_cnt", {16'd0, err_cnt}, 32'd0);
    chk("clr_flag", {31'd0, err_flag}, 32'd0);

    // More range errors at format boundaries
    send(C_SHAMT, 32'd32, 7'h13, 5'd1, 5'd1, 5'd0, 3'd5, 7'h20, 32'h4000_D093, 1'b1);
    send(7'h00,   32'd0, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'h0000_0000, 1'b1);
    send(C_UTYPE, 32'h1234_5001, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_02B7, 1'b1);
    send(C_BTYPE, 32'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0020_8063, 1'b1);
    send(C_ITYPE, 32'hFFFF_F800, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h8000_0093, 1'b0);
    drain();
    chk("err_cnt_4", {16'd0, err_cnt}, 32'd4);

    // clr_err coinciding with an error handshake: clear wins
    out_ready = 1'b0;
    send(C_ITYPE, 32'd2048, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0093, 1'b1);
    for (int n = 0; n < 10 && !out_valid; n++) begin
      @(posedge clk); #1;
    end
    chk("tie_valid", {31'd0, out_valid}, 32'd1);
    clr_err = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
    chk("tie_cnt", {16'd0, err_cnt}, 32'd0);
    chk("tie_flag", {31'd0, err_flag}, 32'd0);
    drain();

    // Backpressure: two accepted, then stall with stable output
    out_ready = 1'b0;
    send(C_ITYPE, 32'd1, 7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'h0011_8113, 1'b0);
    send(C_ITYPE, 32'd2, 7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'h0021_8113, 1'b0);
    held = 32'h0011_8113;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_word_hold", out_word, held);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    hs0 = hs_cnt;
    send(C_ITYPE, 32'd3, 7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'h0031_8113, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("bp_rate", hs_cnt - hs0, 32'd3);
    drain();

    // Reset with both stages full discards them
    out_ready = 1'b0;
    send(C_ITYPE, 32'd2048, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0093, 1'b1);
    send(C_ITYPE, 32'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0070_0093, 1'b0);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_cnt", {16'd0, err_cnt}, 32'd0);
    sb.delete();
    rst = 1'b0; out_ready = 1'b1;
    hs0 = hs_cnt;
    repeat (4) @(posedge clk);
    #1;
    chk("no_stale", hs_cnt - hs0, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
